// File: rtl/pipe_spawn_scheduler.sv
// Purpose : spawn controller for the pipe field; free-running 10-bit XNOR LFSR (taps 10,7),
//           counts frame ticks between spawns and offers each new pipe's gap row to the renderer.
// Latency : the tick that finds the interval counter at 0 -> DRAW (1 cycle) -> spawn_valid next cycle.
// Backpr. : the offer (spawn_valid, gap_pos) is held stable until spawn_ready; ticks seen while
//           drawing/offering are not counted toward the next interval and set the sticky late flag.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start, stop       game-state control (start ignored unless idle, stop wins)
//   tick              1-cycle frame tick
//   spawn_valid/ready valid/ready handshake towards the pipe renderer
//   gap_pos           gap row of the offered pipe, 0..GAP_MAX-1
//   spawn_count       pipes accepted since start, saturating at 255
//   late, busy        sticky tick-while-drawing/offering flag, state != IDLE
//   lfsr_q            current LFSR state (Q[10:1] on bits [9:0])
module pipe_spawn_scheduler #(
    parameter int INTERVAL = 64,
    parameter int GAP_MAX  = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       tick,
    output logic       spawn_valid,
    input  logic       spawn_ready,
    output logic [3:0] gap_pos,
    output logic [7:0] spawn_count,
    output logic       late,
    output logic       busy,
    output logic [9:0] lfsr_q
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DRAW  = 2'd2;
    localparam logic [1:0] S_OFFER = 2'd3;

    localparam logic [7:0] INTERVAL_M1 = 8'(INTERVAL - 1);
    localparam logic [4:0] GAP_MAX_W   = 5'(GAP_MAX);

    logic [1:0] state_q, state_d;
    logic [7:0] counter_q, counter_d;
    logic [9:0] lfsr_d;
    logic [3:0] gap_pos_q, gap_pos_d;
    logic [7:0] spawn_count_q, spawn_count_d;
    logic       late_q, late_d;
    logic       spawn_valid_q, spawn_valid_d;
    logic       busy_q, busy_d;

    logic [3:0] gap_raw;
    logic [3:0] gap_mapped;

    // Fold the 4-bit raw draw into the legal range with a single subtraction;
    // raw < 16 <= 2*GAP_MAX so one fold always suffices.
    always_comb begin
        gap_raw    = lfsr_q[3:0];
        gap_mapped = gap_raw;
        if ({1'b0, gap_raw} >= GAP_MAX_W) begin
            gap_mapped = 4'({1'b0, gap_raw} - GAP_MAX_W);
        end
    end

    always_comb begin
        // XNOR feedback: the all-zero reset state is legal, all-ones is the lock-up state.
        lfsr_d        = {lfsr_q[8:0], ~(lfsr_q[9] ^ lfsr_q[6])};
        state_d       = state_q;
        counter_d     = counter_q;
        gap_pos_d     = gap_pos_q;
        spawn_count_d = spawn_count_q;
        late_d        = late_q;

        case (state_q)
            S_IDLE: begin
                // A tick coinciding with start only loads the counter; it is not counted.
                if (start && !stop) begin
                    state_d       = S_WAIT;
                    counter_d     = INTERVAL_M1;
                    spawn_count_d = 8'd0;
                    late_d        = 1'b0;
                end
            end
            S_WAIT: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    if (counter_q == 8'd0) begin
                        state_d = S_DRAW;
                    end else begin
                        counter_d = counter_q - 8'd1;
                    end
                end
            end
            S_DRAW: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else begin
                    gap_pos_d = gap_mapped;
                    state_d   = S_OFFER;
                end
            end
            S_OFFER: begin
                // stop beats spawn_ready: an aborted offer is never counted.
                if (stop) begin
                    state_d = S_IDLE;
                end else if (spawn_ready) begin
                    state_d   = S_WAIT;
                    counter_d = INTERVAL_M1;
                    if (spawn_count_q != 8'hFF) begin
                        spawn_count_d = spawn_count_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (tick && ((state_q == S_DRAW) || (state_q == S_OFFER))) begin
            late_d = 1'b1;
        end

        // Registered status outputs are computed from the next state so they
        // line up with the state register.
        spawn_valid_d = (state_d == S_OFFER);
        busy_d        = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            counter_q     <= 8'd0;
            lfsr_q        <= 10'd0;
            gap_pos_q     <= 4'd0;
            spawn_count_q <= 8'd0;
            late_q        <= 1'b0;
            spawn_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            counter_q     <= counter_d;
            lfsr_q        <= lfsr_d;
            gap_pos_q     <= gap_pos_d;
            spawn_count_q <= spawn_count_d;
            late_q        <= late_d;
            spawn_valid_q <= spawn_valid_d;
            busy_q        <= busy_d;
        end
    end

    assign spawn_valid = spawn_valid_q;
    assign gap_pos     = gap_pos_q;
    assign spawn_count = spawn_count_q;
    assign late        = late_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_pipe_spawn_scheduler.sv
// Purpose : directed self-checking bench for pipe_spawn_scheduler (INTERVAL=4, GAP_MAX=12).
// Latency : inputs driven and outputs sampled 1 time unit after each rising clk edge.
// Backpr. : spawn_ready driven directly by the stimulus sequence.
module tb_pipe_spawn_scheduler;

    logic       clk;
    logic       reset;
    logic       start;
    logic       stop;
    logic       tick;
    logic       spawn_valid;
    logic       spawn_ready;
    logic [3:0] gap_pos;
    logic [7:0] spawn_count;
    logic       late;
    logic       busy;
    logic [9:0] lfsr_q;

    int n_checks = 0;
    int n_pass   = 0;

    logic [9:0] model_lfsr;
    logic [3:0] exp_gap;

    pipe_spawn_scheduler #(.INTERVAL(4), .GAP_MAX(12)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .tick        (tick),
        .spawn_valid (spawn_valid),
        .spawn_ready (spawn_ready),
        .gap_pos     (gap_pos),
        .spawn_count (spawn_count),
        .late        (late),
        .busy        (busy),
        .lfsr_q      (lfsr_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR: XNOR(Q10,Q7) shifted into the bottom every edge out of reset.
    always @(posedge clk or posedge reset) begin
        if (reset) model_lfsr <= 10'd0;
        else       model_lfsr <= {model_lfsr[8:0], ~(model_lfsr[9] ^ model_lfsr[6])};
    end

    function automatic logic [3:0] gap_map(input logic [3:0] raw);
        return (raw >= 4'd12) ? raw - 4'd12 : raw;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        step();
    endtask

    initial begin : stim
        int acc;
        int cyc;
        logic v;

        reset = 1'b1; start = 1'b0; stop = 1'b0; tick = 1'b0; spawn_ready = 1'b0;
        step();
        step();
        chk("rst_valid", 32'(spawn_valid), 32'd0);
        chk("rst_busy",  32'(busy),        32'd0);
        chk("rst_count", 32'(spawn_count), 32'd0);
        chk("rst_late",  32'(late),        32'd0);
        chk("rst_gap",   32'(gap_pos),     32'd0);
        chk("rst_lfsr",  32'(lfsr_q),      32'd0);

        // 1. four free-running LFSR steps: 0 -> 1 -> 3 -> 7 -> F
        reset = 1'b0;
        repeat (4) step();
        chk("t1_lfsr",  32'(lfsr_q),      32'h00F);
        chk("t1_busy",  32'(busy),        32'd0);
        chk("t1_valid", 32'(spawn_valid), 32'd0);

        // 2. start, four ticks three clocks apart
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t2_busy",  32'(busy),        32'd1);
        chk("t2_valid", 32'(spawn_valid), 32'd0);
        repeat (3) do_tick();
        chk("t2_valid_3ticks", 32'(spawn_valid), 32'd0);
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("t2_valid_draw", 32'(spawn_valid), 32'd0);
        chk("t2_lfsr_model", 32'(lfsr_q), 32'(model_lfsr));
        exp_gap = gap_map(model_lfsr[3:0]);
        step();
        chk("t2_valid_offer", 32'(spawn_valid), 32'd1);
        chk("t2_gap",         32'(gap_pos),     32'(exp_gap));

        // 3. backpressure for 10 clocks with two ticks
        for (int i = 0; i < 10; i++) begin
            tick = (i == 2 || i == 6);
            step();
            tick = 1'b0;
            chk("t3_valid_hold", 32'(spawn_valid), 32'd1);
            chk("t3_gap_hold",   32'(gap_pos),     32'(exp_gap));
        end
        chk("t3_late", 32'(late), 32'd1);
        spawn_ready = 1'b1;
        step();
        spawn_ready = 1'b0;
        chk("t3_valid_drop", 32'(spawn_valid), 32'd0);
        chk("t3_count1",     32'(spawn_count), 32'd1);
        // ready outside OFFER is ignored
        spawn_ready = 1'b1;
        step();
        step();
        spawn_ready = 1'b0;
        chk("t3_ready_wait", 32'(spawn_count), 32'd1);
        repeat (3) do_tick();
        chk("t3_valid_3ticks", 32'(spawn_valid), 32'd0);
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("t3_valid_draw", 32'(spawn_valid), 32'd0);
        exp_gap = gap_map(model_lfsr[3:0]);
        step();
        chk("t3_valid_2nd", 32'(spawn_valid), 32'd1);
        chk("t3_gap_2nd",   32'(gap_pos),     32'(exp_gap));

        // 4. stop beats ready; start+stop in IDLE stays IDLE
        stop = 1'b1; spawn_ready = 1'b1;
        step();
        stop = 1'b0; spawn_ready = 1'b0;
        chk("t4_busy",  32'(busy),        32'd0);
        chk("t4_valid", 32'(spawn_valid), 32'd0);
        chk("t4_count", 32'(spawn_count), 32'd1);
        chk("t4_late",  32'(late),        32'd1);
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        chk("t4_ss_busy", 32'(busy), 32'd0);
        step();
        chk("t4_ss_busy2", 32'(busy),        32'd0);
        chk("t4_ss_count", 32'(spawn_count), 32'd1);

        // 5. async reset between edges while offering
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t5_count_clr", 32'(spawn_count), 32'd0);
        chk("t5_late_clr",  32'(late),        32'd0);
        tick = 1'b1;
        repeat (4) step();
        tick = 1'b0;
        chk("t5_valid_draw", 32'(spawn_valid), 32'd0);
        step();
        chk("t5_valid_offer", 32'(spawn_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_valid", 32'(spawn_valid), 32'd0);
        chk("t5_gap",   32'(gap_pos),     32'd0);
        chk("t5_count", 32'(spawn_count), 32'd0);
        chk("t5_late",  32'(late),        32'd0);
        chk("t5_busy",  32'(busy),        32'd0);
        chk("t5_lfsr",  32'(lfsr_q),      32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        chk("t5_lfsr_restart", 32'(lfsr_q), 32'd1);

        // 6. ready and tick tied high: 300 accepts, saturation, LFSR scoreboard
        spawn_ready = 1'b1; tick = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        chk("t6_busy", 32'(busy), 32'd1);
        // the tick coincident with start is not counted: 4 further ticks, then DRAW
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t6_valid_early", 32'(spawn_valid), 32'd0);
        end
        step();
        chk("t6_valid_first", 32'(spawn_valid), 32'd1);
        acc = 0;
        cyc = 0;
        while (acc < 300 && cyc < 3000) begin
            v = spawn_valid;
            if (v) begin
                chk("t6_gap_range", 32'(gap_pos < 4'd12), 32'd1);
                chk("t6_lfsr",      32'(lfsr_q),          32'(model_lfsr));
            end
            step();
            cyc++;
            if (v) begin
                acc++;
                chk("t6_count", 32'(spawn_count), 32'((acc > 255) ? 255 : acc));
            end
        end
        chk("t6_accepts",  32'(acc),         32'd300);
        chk("t6_count_sat", 32'(spawn_count), 32'd255);
        chk("t6_late",     32'(late),        32'd1);
        spawn_ready = 1'b0; tick = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
